// File: rtl/line_buffer_pkg.sv
// -----------------------------------------------------------------------------
// line_buffer_pkg
//   Shared definitions for the one-line write-back buffer responder:
//   - state_t      : responder FSM states
//   - *_DEFAULT    : default line geometry (256-bit line, 5 byte-offset bits)
//   - merge_word() : byte-enable merge of a CPU write into a buffered word
// -----------------------------------------------------------------------------
package line_buffer_pkg;

  localparam int LINE_BITS_DEFAULT   = 256;
  localparam int OFFSET_BITS_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    RESP
  } state_t;

  // Returns old_word with every byte whose enable bit is set replaced by the
  // corresponding byte of wdata.
  function automatic logic [31:0] merge_word(
    input logic [31:0] old_word,
    input logic [31:0] wdata,
    input logic [3:0]  byte_enable
  );
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (byte_enable[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/line_buffer_datapath.sv
// -----------------------------------------------------------------------------
// line_buffer_datapath
//   Storage and data steering for the line buffer: the buffered line, its tag,
//   and the request latched on acceptance. Presents the word addressed by the
//   latched request and merges byte-enabled write data into it.
//
// Ports:
//   clk              : clock
//   accept           : latch the presented request fields this cycle
//   fill             : load line from pmem_rdata and tag from the latched request
//   merge            : merge latched write data into the selected word
//   mem_word_address : CPU word address (byte address bits [31:2])
//   mem_wdata        : CPU write data
//   mem_byte_enable  : CPU per-byte write enable
//   mem_write        : request is a write
//   pmem_rdata       : fetched line
//   line             : buffered line (also the writeback data)
//   tag              : tag of the buffered line
//   req_tag          : line address of the latched request
//   req_is_write     : latched request is a write
//   req_word         : word of the buffered line selected by the latched request
// -----------------------------------------------------------------------------
module line_buffer_datapath
  import line_buffer_pkg::*;
#(
  parameter int LINE_BITS   = LINE_BITS_DEFAULT,
  parameter int OFFSET_BITS = OFFSET_BITS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    accept,
  input  logic                    fill,
  input  logic                    merge,
  input  logic [31:2]             mem_word_address,
  input  logic [31:0]             mem_wdata,
  input  logic [3:0]              mem_byte_enable,
  input  logic                    mem_write,
  input  logic [LINE_BITS-1:0]    pmem_rdata,
  output logic [LINE_BITS-1:0]    line,
  output logic [31-OFFSET_BITS:0] tag,
  output logic [31-OFFSET_BITS:0] req_tag,
  output logic                    req_is_write,
  output logic [31:0]             req_word
);

  localparam int WORD_SEL_BITS = OFFSET_BITS - 2;

  logic [WORD_SEL_BITS-1:0] req_word_sel;
  logic [31:0]              req_wdata;
  logic [3:0]               req_byte_enable;

  // The pre-merge word doubles as the read data for both reads and writes.
  assign req_word = line[32*int'(req_word_sel) +: 32];

  // NOTE: line, tag and the request registers carry no reset; valid (in the
  // top) qualifies their contents, so clearing them would only cost reset fanout.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_tag         <= mem_word_address[31:OFFSET_BITS];
      req_word_sel    <= mem_word_address[OFFSET_BITS-1:2];
      req_wdata       <= mem_wdata;
      req_byte_enable <= mem_byte_enable;
      req_is_write    <= mem_write;
    end

    if (fill) begin
      line <= pmem_rdata;
      tag  <= req_tag;
    end else if (merge) begin
      line[32*int'(req_word_sel) +: 32] <= merge_word(req_word, req_wdata, req_byte_enable);
    end
  end

endmodule

// File: rtl/line_buffer_responder.sv
// -----------------------------------------------------------------------------
// line_buffer_responder
//   Memory-side responder for a blocking CPU word interface. Serves requests
//   from a single write-back line buffer; a miss writes back the dirty line
//   (if any) and fetches the new one over a line-wide pmem handshake. Every
//   accepted request produces exactly one single-cycle mem_resp.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   mem_read/mem_write: CPU request (write wins if both are high)
//   mem_address       : CPU byte address, bits [1:0] ignored
//   mem_wdata         : CPU write data
//   mem_byte_enable   : CPU per-byte write enable
//   mem_rdata         : read data, valid while mem_resp is high
//   mem_resp          : one-cycle completion pulse
//   pmem_read         : line fetch request, held until pmem_resp
//   pmem_write        : line writeback request, held until pmem_resp
//   pmem_address      : line-aligned physical address
//   pmem_wdata        : writeback line
//   pmem_rdata        : fetched line, valid with pmem_resp
//   pmem_resp         : physical memory completion pulse
// -----------------------------------------------------------------------------
module line_buffer_responder
  import line_buffer_pkg::*;
#(
  parameter int LINE_BITS   = LINE_BITS_DEFAULT,
  parameter int OFFSET_BITS = OFFSET_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [31:0]          mem_address,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_byte_enable,
  output logic [31:0]          mem_rdata,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [31:0]          pmem_address,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);

  state_t state, state_next;

  logic                    valid;
  logic                    dirty;
  logic                    request;
  logic                    hit;
  logic                    accept;
  logic                    fill;
  logic                    merge;
  logic [LINE_BITS-1:0]    line;
  logic [31-OFFSET_BITS:0] tag;
  logic [31-OFFSET_BITS:0] req_tag;
  logic                    req_is_write;
  logic [31:0]             req_word;
  logic                    unused_addr_bits;

  // Byte lane within a word is irrelevant: accesses are whole words plus enables.
  assign unused_addr_bits = ^mem_address[1:0];

  assign request = mem_read | mem_write;
  assign hit     = valid && (tag == mem_address[31:OFFSET_BITS]);

  // Gating with rst keeps an in-flight pmem_resp or write merge from touching
  // the buffer while the transaction is being abandoned.
  assign accept = (state == IDLE)  && request      && !rst;
  assign fill   = (state == FETCH) && pmem_resp    && !rst;
  assign merge  = (state == RESP)  && req_is_write && !rst;

  assign pmem_wdata = line;

  line_buffer_datapath #(
    .LINE_BITS   (LINE_BITS),
    .OFFSET_BITS (OFFSET_BITS)
  ) u_datapath (
    .clk              (clk),
    .accept           (accept),
    .fill             (fill),
    .merge            (merge),
    .mem_word_address (mem_address[31:2]),
    .mem_wdata        (mem_wdata),
    .mem_byte_enable  (mem_byte_enable),
    .mem_write        (mem_write),
    .pmem_rdata       (pmem_rdata),
    .line             (line),
    .tag              (tag),
    .req_tag          (req_tag),
    .req_is_write     (req_is_write),
    .req_word         (req_word)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= 1'b0;
      dirty <= 1'b0;
    end else begin
      state <= state_next;
      if (fill) begin
        valid <= 1'b1;
        dirty <= 1'b0;
      end else if ((state == WRITEBACK) && pmem_resp) begin
        dirty <= 1'b0;
      end else if (merge) begin
        dirty <= 1'b1;
      end
    end
  end

  // NOTE: every output of this block is assigned a default first so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_next   = state;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;

    case (state)
      IDLE: begin
        if (request) begin
          if (hit)        state_next = RESP;
          else if (dirty) state_next = WRITEBACK;
          else            state_next = FETCH;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag, {OFFSET_BITS{1'b0}}};
        if (pmem_resp) state_next = FETCH;
      end
      FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, {OFFSET_BITS{1'b0}}};
        if (pmem_resp) state_next = RESP;
      end
      RESP: begin
        mem_resp   = 1'b1;
        mem_rdata  = req_word;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_line_buffer_responder.sv
// -----------------------------------------------------------------------------
// tb_line_buffer_responder
//   Scoreboard bench for line_buffer_responder. The driver computes every
//   expected read word and pmem transaction from an abstract buffer model and
//   queues them; independent monitor and pmem-responder processes pop and
//   compare whenever the DUT presents mem_resp or a pmem request.
// -----------------------------------------------------------------------------
module tb_line_buffer_responder;

  localparam int LB = 256;

  typedef struct packed {
    logic          is_write;
    logic [31:0]   addr;
    logic [LB-1:0] data;
  } pmem_txn_t;

  logic          clk;
  logic          rst;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_address;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_byte_enable;
  logic [31:0]   mem_rdata;
  logic          mem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_address;
  logic [LB-1:0] pmem_wdata;
  logic [LB-1:0] pmem_rdata;
  logic          pmem_resp;

  // pmem responder drive
  logic          resp_pulse;
  logic [LB-1:0] resp_data;
  logic          stray_req;
  logic          hold_pmem;

  assign pmem_resp  = resp_pulse | stray_req;
  assign pmem_rdata = stray_req ? {8{32'hBAD0BAD0}} : resp_data;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // Scoreboard queues
  logic [31:0] exp_rdata[$];
  pmem_txn_t   exp_pmem[$];

  // Reference model: architectural buffer contents and physical memory view
  bit            m_valid;
  bit            m_dirty;
  logic [26:0]   m_tag;
  logic [LB-1:0] m_line;
  logic [LB-1:0] ref_mem  [logic [26:0]];
  logic [LB-1:0] phys_mem [logic [26:0]];

  line_buffer_responder dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Initial physical memory contents; line 0x100 carries 0xDEADBEEF in word 1.
  function automatic logic [LB-1:0] init_line(input logic [26:0] la);
    logic [LB-1:0] l;
    for (int w = 0; w < 8; w++) begin
      l[32*w +: 32] = {la[15:0], 8'h5A, 5'd0, 3'(w)};
    end
    if (la == 27'h8) l[63:32] = 32'hDEADBEEF;
    return l;
  endfunction

  function automatic logic [LB-1:0] ref_line(input logic [26:0] la);
    return ref_mem.exists(la) ? ref_mem[la] : init_line(la);
  endfunction

  function automatic logic [LB-1:0] phys_line(input logic [26:0] la);
    return phys_mem.exists(la) ? phys_mem[la] : init_line(la);
  endfunction

  // Issues one request (called at a negedge), queues its expectations, waits
  // for mem_resp and leaves the bench at the negedge of the following IDLE cycle.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input bit drop_early);
    logic [26:0] la;
    int          w;
    bit          hit;
    bit          got;
    int          lat;
    la  = addr[31:5];
    w   = int'(addr[4:2]);
    hit = m_valid && (m_tag == la);
    if (!hit) begin
      if (m_dirty) begin
        exp_pmem.push_back('{1'b1, {m_tag, 5'b0}, m_line});
        ref_mem[m_tag] = m_line;
      end
      exp_pmem.push_back('{1'b0, {la, 5'b0}, '0});
      m_line  = ref_line(la);
      m_tag   = la;
      m_valid = 1'b1;
      m_dirty = 1'b0;
    end
    exp_rdata.push_back(m_line[32*w +: 32]);
    if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) m_line[32*w + 8*b +: 8] = wdata[8*b +: 8];
      end
      m_dirty = 1'b1;
    end

    mem_read        = rd;
    mem_write       = wr;
    mem_address     = addr;
    mem_wdata       = wdata;
    mem_byte_enable = be;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 200 && !got; c++) begin
      @(negedge clk);
      if (mem_resp) begin
        got = 1'b1;
        lat = c + 1;
      end else if (drop_early) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    end
    check("mem_resp_timeout", got, 1);
    if (hit) check("hit_latency", lat, 2);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard monitor for the CPU side plus protocol invariants.
  initial begin
    logic [31:0] e;
    bit prev_resp;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (started) begin
        if (mem_resp) begin
          if (exp_rdata.size() == 0) begin
            check("spurious_mem_resp", mem_resp, 0);
          end else begin
            e = exp_rdata.pop_front();
            check("mem_rdata", mem_rdata, e);
          end
        end
        check("pmem_rw_exclusive", pmem_read && pmem_write, 0);
        check("mem_resp_consecutive", mem_resp && prev_resp, 0);
        prev_resp = mem_resp;
      end
    end
  end

  // Physical memory responder: checks each pmem request against the queue,
  // answers after a random delay, and stores written-back lines.
  initial begin
    bit          busy;
    int          delay;
    bit          cur_wr;
    logic [31:0] cur_addr;
    logic [LB-1:0] cur_data;
    pmem_txn_t   t;
    busy       = 1'b0;
    delay      = 0;
    resp_pulse = 1'b0;
    resp_data  = '0;
    forever begin
      @(negedge clk);
      resp_pulse = 1'b0;
      if (!(pmem_read || pmem_write) || !started) begin
        busy = 1'b0;
      end else if (!busy) begin
        busy     = 1'b1;
        cur_wr   = pmem_write;
        cur_addr = pmem_address;
        cur_data = pmem_wdata;
        delay    = $urandom_range(0, 3);
        if (exp_pmem.size() == 0) begin
          check("unexpected_pmem_request", {pmem_read, pmem_write}, 0);
        end else begin
          t = exp_pmem.pop_front();
          check("pmem_is_write", pmem_write, t.is_write);
          check("pmem_address", pmem_address, t.addr);
          if (t.is_write) check("pmem_wdata", pmem_wdata, t.data);
        end
      end else if (!hold_pmem) begin
        if (delay == 0) begin
          resp_pulse = 1'b1;
          resp_data  = phys_line(cur_addr[31:5]);
          if (cur_wr) phys_mem[cur_addr[31:5]] = cur_data;
          busy = 1'b0;
        end else begin
          delay--;
        end
      end
    end
  end

  // Abandon a fetch with reset; stray pmem_resp pulses during reset are ignored.
  task automatic reset_during_fetch(input logic [31:0] addr);
    bit seen;
    hold_pmem = 1'b1;
    exp_pmem.push_back('{1'b0, {addr[31:5], 5'b0}, '0});
    mem_read    = 1'b1;
    mem_address = addr;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (pmem_read) seen = 1'b1;
    end
    check("aborted_fetch_started", seen, 1);
    repeat (2) @(negedge clk);
    rst      = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    check("pmem_read_drops_after_rst", pmem_read, 0);
    stray_req = 1'b1;
    repeat (2) @(negedge clk);
    stray_req = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    hold_pmem = 1'b0;
    m_valid   = 1'b0;
    m_dirty   = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
    stray_req       = 1'b0;
    hold_pmem       = 1'b0;
    m_valid         = 1'b0;
    m_dirty         = 1'b0;
    m_tag           = '0;
    m_line          = '0;

    repeat (3) @(negedge clk);
    check("reset_mem_resp", mem_resp, 0);
    check("reset_pmem_read", pmem_read, 0);
    check("reset_pmem_write", pmem_write, 0);
    check("reset_mem_rdata", mem_rdata, 0);
    check("reset_pmem_address", pmem_address, 0);
    rst     = 1'b0;
    started = 1'b1;
    @(negedge clk);

    // Clean miss, hit, partial write, dirty miss
    do_req(1, 0, 32'h0000_0104, 32'h0, 4'h0, 0);
    do_req(1, 0, 32'h0000_0108, 32'h0, 4'h0, 0);
    do_req(0, 1, 32'h0000_0104, 32'h1122_3344, 4'b0101, 0);
    do_req(1, 0, 32'h0000_0104, 32'h0, 4'h0, 0);
    do_req(1, 0, 32'h0000_0204, 32'h0, 4'h0, 0);

    // Reset during fetch, then a fresh fetch without writeback
    reset_during_fetch(32'h0000_0304);
    do_req(1, 0, 32'h0000_0104, 32'h0, 4'h0, 0);

    // Read and write both high is a write
    do_req(1, 1, 32'h0000_0100, 32'hA5A5_A5A5, 4'hF, 0);
    do_req(1, 0, 32'h0000_0100, 32'h0, 4'h0, 0);

    // Randomized traffic over a handful of neighbouring lines
    for (int i = 0; i < 300; i++) begin
      logic [26:0] la_r;
      logic [31:0] r;
      int          op;
      la_r = 27'(8 + $urandom_range(0, 5));
      r    = $urandom;
      op   = $urandom_range(0, 3);
      do_req(op != 2, op >= 2, {la_r, r[4:0]}, $urandom, 4'($urandom),
             $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check("pending_rdata", exp_rdata.size(), 0);
    check("pending_pmem", exp_pmem.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_buffer_responder.md
Name: line_buffer_responder

Overview:
- Memory-side responder for the CPU pipeline's blocking request interface.
- Accepts one word request at a time (mem_read/mem_write) and returns exactly one single-cycle mem_resp per accepted request.
- Serves requests from a one-line write-back buffer; misses go through a line-wide handshake to physical memory.
- Sits between the pipeline's memory-stage blocking logic and the physical memory / arbiter port.

Parameters:
- LINE_BITS, 256, width of one buffered line and of the pmem data buses.
- OFFSET_BITS, 5, byte-offset bits within a line (log2(LINE_BITS/8)).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mem_read  input  1  CPU read request, held until mem_resp
- mem_write  input  1  CPU write request, held until mem_resp
- mem_address  input  32  CPU byte address; bits [1:0] ignored
- mem_wdata  input  32  CPU write data
- mem_byte_enable  input  4  per-byte write enable for mem_wdata
- mem_rdata  output  32  read data; valid in the mem_resp cycle
- mem_resp  output  1  one-cycle completion pulse
- pmem_read  output  1  line fetch request, held until pmem_resp
- pmem_write  output  1  line writeback request, held until pmem_resp
- pmem_address  output  32  line-aligned address, low OFFSET_BITS bits zero
- pmem_wdata  output  LINE_BITS  writeback line data
- pmem_rdata  input  LINE_BITS  fetched line data, valid with pmem_resp
- pmem_resp  input  1  physical memory completion, one cycle

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- State held: line[LINE_BITS], tag[31-OFFSET_BITS:0], valid, dirty, and a latched request (address, wdata, byte_enable, is_write).
- Reset values:
  - state=IDLE; valid=0; dirty=0.
  - mem_resp=0, pmem_read=0, pmem_write=0; mem_rdata=0; pmem_address=0.
- Reset mid-operation:
  - Abandons any transaction with no mem_resp.
  - pmem_read/pmem_write drop in the cycle after rst is sampled.
  - A pmem_resp arriving during or after reset is ignored.
- Request:
  - mem_read|mem_write is sampled only in IDLE.
  - If both are high, the request is a write.
  - The request fields are latched on acceptance.
- Hit test: hit = valid && tag == mem_address[31:OFFSET_BITS].
- IDLE:
  - No request -> IDLE.
  - Hit -> RESP.
  - Miss with dirty=1 -> WRITEBACK.
  - Miss with dirty=0 -> FETCH.
- WRITEBACK:
  - pmem_write=1; pmem_address={tag, OFFSET_BITS'b0}; pmem_wdata=line.
  - On pmem_resp: dirty<=0, -> FETCH.
- FETCH:
  - pmem_read=1; pmem_address={latched addr[31:OFFSET_BITS], OFFSET_BITS'b0}.
  - On pmem_resp: line<=pmem_rdata, tag<=latched tag, valid<=1, dirty<=0, -> RESP.
- RESP:
  - mem_resp=1 for exactly one cycle.
  - Word select = latched addr[OFFSET_BITS-1:2].
  - Read: mem_rdata = selected word of line.
  - Write: bytes with byte_enable=1 are merged into that word at the clock edge; dirty<=1; mem_rdata = pre-merge word.
  - Next state is IDLE.
- Latency:
  - Hit: mem_resp in the 2nd cycle after the request is presented (IDLE, then RESP).
  - Clean miss: IDLE + FETCH(n) + RESP.
  - Dirty miss: adds the WRITEBACK cycles.
- Back-to-back: the requester may present a new request in the cycle after mem_resp; it is accepted in that IDLE cycle.
- Request dropped before mem_resp: the transaction still completes and the buffer is still updated. The mem_resp pulse is still emitted; the requester ignores it.
- pmem_resp outside WRITEBACK/FETCH is ignored.
- pmem_read and pmem_write are never high together.
- mem_resp is never high in two consecutive cycles.

Decomposition:
- Shared package line_buffer_pkg holds:
  - state enum {IDLE, WRITEBACK, FETCH, RESP};
  - LINE_BITS and OFFSET_BITS defaults;
  - a word-select/byte-merge function used by the datapath.
- One natural sub-module, line_buffer_datapath: line, tag and request registers, word select, byte merge.
- The FSM and pmem handshake stay in the top module.

Test Plan:
1. Reset, then read 0x00000104 with pmem returning a line whose word1=0xDEADBEEF -> exactly one pmem_read with pmem_address=0x00000100; mem_resp single pulse; mem_rdata=0xDEADBEEF.
2. Read 0x00000108 after (1), held high -> no pmem activity; mem_resp on the 2nd cycle; rdata = line word2.
3. Write 0x00000104, wdata=0x11223344, byte_enable=0b0101; then read 0x00000104 -> rdata=0xDE22BE44; no pmem traffic.
4. After (3), read 0x00000204 -> pmem_write with pmem_address=0x00000100 and the merged line first; then pmem_read at 0x00000200; one mem_resp total.
5. Assert rst during FETCH before pmem_resp; then read 0x00000104 -> no mem_resp from the aborted request; valid=0, so a fresh FETCH occurs; no writeback.
6. mem_read and mem_write both high at 0x00000100 (hit), be=0b1111, wdata=0xA5A5A5A5 -> treated as write; a subsequent read returns 0xA5A5A5A5.
